// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit engines.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_PHASE  = 4'd7;

   // Divisor values (cfg_div) for common baud rates at 16 MHz and 144 MHz.
   localparam logic [15:0] BAUD_16M_115200  = 16'h0008;
   localparam logic [15:0] BAUD_16M_9600    = 16'h0067;
   localparam logic [15:0] BAUD_16M_4800    = 16'h00CF;
   localparam logic [15:0] BAUD_144M_115200 = 16'h004D;
   localparam logic [15:0] BAUD_144M_9600   = 16'h03A9;
   localparam logic [15:0] BAUD_144M_4800   = 16'h0752;

endpackage

// File: rtl/uart_rx_core_if.sv
// Held-byte output channel of the UART receiver (valid/ready plus error flags).
interface uart_rx_core_if #(
   parameter int DATA_W = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_parity_err;
   logic              out_frame_err;

   modport master (
      output out_valid,
      output out_data,
      output out_parity_err,
      output out_frame_err,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_parity_err,
      input  out_frame_err,
      output out_ready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div and emits tick on the terminal count.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // Free-running divisor counter, held at zero while cleared.
   always_ff @(posedge clock) begin
      if (reset || clear)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = !clear && (cnt == div);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled framing recovery with a one-entry output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on rxs (armed once rxs seen high)
// ST_START  | confirming the start bit at mid-bit, glitches return to idle
// ST_DATA   | sampling DATA_W data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit; frame completes mid stop bit
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_en,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_odd,
   input  logic             rxd,
   uart_rx_core_if.master   out_if,
   output logic             overrun,
   output logic             busy
);

   localparam int                PH_W     = $clog2(OVERSAMPLE);
   localparam int                BIT_W    = $clog2(DATA_W) + 1;
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

   uart_state_t       state, state_nxt;
   logic              sync_q, rxs, armed;
   logic [DIV_W-1:0]  div_l;
   logic              par_en_l, par_odd_l;
   logic              tick, sample;
   logic [PH_W-1:0]   phase;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_err_q;
   logic              shift_en, par_smp, done;

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clock (clock),
      .reset (reset),
      .clear (state == ST_IDLE),
      .div   (div_l),
      .tick  (tick)
   );

   assign sample = tick && (phase == MID_PHASE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; disabling the receiver aborts any frame in progress.
   always_comb begin
      state_nxt = state;
      if (!cfg_en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (armed && !rxs) state_nxt = ST_START;
            ST_START:  if (sample) state_nxt = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample && (bit_cnt == LAST_BIT))
                          state_nxt = par_en_l ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample) state_nxt = ST_STOP;
            ST_STOP:   if (sample) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Per-state strobes for the datapath and the output register.
   always_comb begin
      busy     = (state != ST_IDLE);
      shift_en = (state == ST_DATA) && sample;
      par_smp  = (state == ST_PARITY) && sample;
      done     = cfg_en && (state == ST_STOP) && sample;
   end

   // Synchronizer, arming, config latch, phase/bit counters and shift register.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q    <= 1'b1;
         rxs       <= 1'b1;
         armed     <= 1'b0;
         div_l     <= '0;
         par_en_l  <= 1'b0;
         par_odd_l <= 1'b0;
         phase     <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_err_q <= 1'b0;
      end else begin
         sync_q <= rxd;
         rxs    <= sync_q;
         // Re-arming needs a high line, so a held break yields a single frame.
         armed  <= (state == ST_IDLE) && (armed || rxs);
         if (state == ST_IDLE) begin
            div_l     <= cfg_div;
            par_en_l  <= cfg_parity_en;
            par_odd_l <= cfg_parity_odd;
            phase     <= '0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
         end else if (tick) begin
            phase <= phase + 1'b1;
         end
         if (shift_en) begin
            shreg   <= {rxs, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (par_smp)
            par_err_q <= (((^shreg) ^ rxs) != par_odd_l);
      end
   end

   // Single-entry holding register; a full, stalled register drops the new frame.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_if.out_valid      <= 1'b0;
         out_if.out_data       <= '0;
         out_if.out_parity_err <= 1'b0;
         out_if.out_frame_err  <= 1'b0;
         overrun               <= 1'b0;
      end else begin
         overrun <= done && out_if.out_valid && !out_if.out_ready;
         if (done && (!out_if.out_valid || out_if.out_ready)) begin
            out_if.out_valid      <= 1'b1;
            out_if.out_data       <= shreg;
            out_if.out_parity_err <= par_err_q;
            out_if.out_frame_err  <= !rxs;
         end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial UART receive engine for the UART peripheral. It oversamples the `rxd` pin at 16× the bit rate, using the same divisor encoding as the UART_CSR baud field. It recovers start/data/parity/stop framing, LSB first, and presents each received byte with error flags on a single-entry valid/ready output. It sits between the `rxd` pad and the register/bus front end. Its output is the byte source for DATA_REG reads and the rx status bit.

## Interface
Parameters:
- `DIV_W`, 16: width of the baud divisor.
- `DATA_W`, 8: data bits per frame.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_en`  in  1  receiver enable.
- `cfg_div`  in  DIV_W  tick divisor. Oversample tick period = `cfg_div`+1 clocks; bit period = 16×(`cfg_div`+1) clocks.
- `cfg_parity_en`  in  1  a parity bit follows the data bits.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `rxd`  in  1  asynchronous serial input; idles high.
- `out_valid`  out  1  received byte held.
- `out_ready`  in  1  consumer accepts the held byte.
- `out_data`  out  DATA_W  received byte.
- `out_parity_err`  out  1  parity mismatch for the held byte.
- `out_frame_err`  out  1  stop bit sampled low for the held byte.
- `overrun`  out  1  one-cycle pulse: a frame completed while `out_valid`=1 and `out_ready`=0.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **Input synchronizer.** `rxd` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rxs`.
- **Tick generator.** Counter runs 0..`cfg_div`; `tick` is asserted when the counter equals `cfg_div`. The counter is cleared when leaving IDLE.
- **Phase counter.** A 4-bit phase counter counts ticks within a bit. The sample point is the tick where phase = 7 (mid-bit).
- **Config latching.** `cfg_div`, `cfg_parity_en` and `cfg_parity_odd` are latched on leaving IDLE. Changes mid-frame have no effect on the current frame.

State machine:
- **IDLE.** Armed only after `rxs` has been seen high. On `rxs`=0 with `cfg_en`=1 → START.
- **START.** At the mid-bit sample: `rxs`=1 → IDLE (glitch rejected, no output); `rxs`=0 → DATA.
- **DATA.** Samples `DATA_W` bits at mid-bit, shifted in LSB first. After the last bit → PARITY if parity is enabled, else → STOP.
- **PARITY.** Samples the parity bit. Error if (XOR of data bits ^ parity bit) ≠ `cfg_parity_odd`.
- **STOP.** At the mid-bit sample: the frame completes, `frame_err` = ~`rxs`, and the state goes to IDLE immediately (mid stop bit) so the next start edge is caught.
- **Break.** When the stop bit is low, IDLE requires `rxs`=1 before re-arming, so a held-low line produces exactly one frame with `frame_err`=1.

Output register:
- On frame completion with the holding register empty, or with `out_valid`&`out_ready` in the same cycle: load data and flags and set `out_valid`.
- On frame completion with the register full and `out_ready`=0: pulse `overrun`; the new frame is dropped and the old contents are kept.
- `out_valid` clears on `out_valid`&`out_ready` when no new frame completes in that cycle.

Enable and reset:
- `cfg_en`=0 forces the state to IDLE on the next clock; the holding register is unaffected.
- `reset` (from any state, including mid-frame): state IDLE; synchronizer = 1; counters = 0; all outputs 0 (`out_data` = 0).

## Timing
- `rxd` to `rxs` latency is 2 clocks.
- Start sample occurs 8 ticks after the first low `rxs`. Each following sample is 16 ticks later.
- `out_valid` rises 1 clock after the stop-bit sample tick. For 8N1, that is 8+16×9 = 152 ticks after the start edge; 8E1 adds 16 ticks.
- `overrun` is high for exactly the completion cycle.
- Handshake: `out_data` and the flags are stable while `out_valid`=1 and `out_ready`=0. The transfer occurs on the rising edge where both are high.
- At `cfg_div`=0, a tick occurs every clock; this is the minimum bit period of 16 clocks.

## Structure
- Shared package `uart_pkg`:
  - state enum (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - `OVERSAMPLE`=16 and `MID_PHASE`=7;
  - baud constants for 16 MHz and 144 MHz (0x8/0x67/0xCF and 0x4D/0x3A9/0x752).
- One sub-module: `uart_baud_tick` (divisor counter with clear, emits `tick`). The same sub-module is reused by the transmitter.

## Test plan
All scenarios use `cfg_div`=8 (bit period 144 clocks) unless stated.
1. Send 0x55, even parity, parity bit 0, `out_ready`=1 → one `out_valid` beat, `out_data`=0x55, both error flags 0.
2. Send 0xA3 with even parity enabled and parity bit 1 (wrong) → `out_data`=0xA3, `out_parity_err`=1; repeat with `cfg_parity_odd`=1 → `out_parity_err`=0.
3. Send 0x3C 8N1 with the stop bit driven low, then hold `rxd` low for 3 bit times → exactly one beat with `out_frame_err`=1, no further frames until `rxd` returns high.
4. Pull `rxd` low for 4 ticks (36 clocks), then high → no output, `busy` returns to 0 before the start sample + 1 tick.
5. Send 0x11 then 0x22 back-to-back with `out_ready`=0 → `overrun` pulses once at the second stop sample; a subsequent `out_ready` returns 0x11.
6. Assert `reset` during bit 4 of a frame, then send 0x7E → no beat for the aborted frame, 0x7E is received correctly, all outputs 0 during reset.
